// File: rtl/if1_fetch_skid.sv
`default_nettype none
// ============================================================================
// Module  : if1_fetch_skid
// Purpose : IF1 -> fetch-buffer skid FIFO with per-slot serialising-instruction
//           trim and front-end redirect FSM. Optional perf counters are built
//           when IF1_SKID_PERF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module if1_fetch_skid #(
  parameter int unsigned FETCH_W    = 2,
  parameter int unsigned SKID_DEPTH = 2,
  parameter logic [31:0] PC_RESET   = 32'h1c000000,
  parameter logic [31:0] INST_NOP   = 32'h03400000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_pc_next,
  input  logic [32*FETCH_W-1:0]  in_inst,
  input  logic [31:0]            in_badv,
  input  logic [6:0]             in_excp,
  input  logic [1:0]             in_excp_flag,
  input  logic [FETCH_W-1:0]     in_serial,
  input  logic [2*FETCH_W-1:0]   in_serial_type,
  input  logic                   ex_serial_commit,
  input  logic                   cache_idle,
  input  logic                   csr_done,
  input  logic                   tlb_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_pc_next,
  output logic [32*FETCH_W-1:0]  out_inst,
  output logic [FETCH_W-1:0]     out_mask,
  output logic [31:0]            out_badv,
  output logic [6:0]             out_excp,
  output logic [1:0]             out_excp_flag,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
`ifdef IF1_SKID_PERF_EN
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_serial_cnt,
`endif
  output logic                   flush_front
);

  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_IBAR   = 3'd1,
    S_W_CACHE  = 3'd2,
    S_W_CSR    = 3'd3,
    S_W_CSR_OK = 3'd4,
    S_W_TLB    = 3'd5,
    S_W_TLB_OK = 3'd6
  } state_t;

  state_t                r_state;
  logic                  r_redirect_valid;
  logic                  r_flush_front;
  logic [31:0]           r_redirect_pc;

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [31:0]           r_pc       [SKID_DEPTH];
  logic [31:0]           r_pc_next  [SKID_DEPTH];
  logic [32*FETCH_W-1:0] r_inst     [SKID_DEPTH];
  logic [FETCH_W-1:0]    r_mask     [SKID_DEPTH];
  logic [31:0]           r_badv     [SKID_DEPTH];
  logic [6:0]            r_excp     [SKID_DEPTH];
  logic [1:0]            r_excp_flag[SKID_DEPTH];

  logic                  w_head_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_trim;
  logic                  w_found;
  logic [2:0]            w_k;
  logic [1:0]            w_trim_type;
  logic [31:0]           w_trim_pc;
  logic [FETCH_W-1:0]    w_push_mask;
  logic [32*FETCH_W-1:0] w_push_inst;
  logic [31:0]           w_push_pc_next;

  assign w_head_valid = (r_count != '0);
  assign in_ready     = (r_count < CNT_W'(SKID_DEPTH)) && (r_state == S_IDLE);
  assign w_push       = in_valid && in_ready;
  assign w_pop        = w_head_valid && out_ready;

  // An exception-carrying packet is never trimmed; the fault takes priority.
  assign w_trim = (in_excp_flag == 2'b00) && (|in_serial);

  always_comb begin
    w_found     = 1'b0;
    w_k         = 3'd0;
    w_trim_type = 2'd0;
    for (int i = 0; i < int'(FETCH_W); i++) begin
      if (!w_found && in_serial[i]) begin
        w_found     = 1'b1;
        w_k         = 3'(i);
        w_trim_type = in_serial_type[2*i +: 2];
      end
    end
  end

  assign w_trim_pc = in_pc + {27'd0, w_k + 3'd1, 2'b00};

  always_comb begin
    w_push_mask    = '1;
    w_push_inst    = in_inst;
    w_push_pc_next = in_pc_next;
    if (w_trim) begin
      w_push_pc_next = w_trim_pc;
      for (int i = 0; i < int'(FETCH_W); i++) begin
        if (3'(i) > w_k) begin
          w_push_mask[i]         = 1'b0;
          w_push_inst[32*i +: 32] = INST_NOP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rstn && !flush && w_push) begin
      r_pc[r_wr_ptr]        <= in_pc;
      r_pc_next[r_wr_ptr]   <= w_push_pc_next;
      r_inst[r_wr_ptr]      <= w_push_inst;
      r_mask[r_wr_ptr]      <= w_push_mask;
      r_badv[r_wr_ptr]      <= in_badv;
      r_excp[r_wr_ptr]      <= in_excp;
      r_excp_flag[r_wr_ptr] <= in_excp_flag;
    end
  end

  assign out_valid     = w_head_valid;
  assign out_pc        = w_head_valid ? r_pc[r_rd_ptr]        : PC_RESET;
  assign out_pc_next   = w_head_valid ? r_pc_next[r_rd_ptr]   : PC_RESET + 32'd4;
  assign out_inst      = w_head_valid ? r_inst[r_rd_ptr]      : {FETCH_W{INST_NOP}};
  assign out_mask      = w_head_valid ? r_mask[r_rd_ptr]      : '0;
  assign out_badv      = w_head_valid ? r_badv[r_rd_ptr]      : 32'd0;
  assign out_excp      = w_head_valid ? r_excp[r_rd_ptr]      : 7'd0;
  assign out_excp_flag = w_head_valid ? r_excp_flag[r_rd_ptr] : 2'd0;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_state          <= S_IDLE;
      r_redirect_valid <= 1'b0;
      r_flush_front    <= 1'b0;
      r_redirect_pc    <= PC_RESET;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_push && w_trim) begin
            r_redirect_pc    <= w_trim_pc;
            r_redirect_valid <= 1'b1;
            r_flush_front    <= 1'b1;
            // Unknown type 3 is handled as ibar: full serialisation is the safe choice.
            case (w_trim_type)
              2'd1:    r_state <= S_W_CSR;
              2'd2:    r_state <= S_W_TLB;
              default: r_state <= S_W_IBAR;
            endcase
          end
        end
        S_W_IBAR: begin
          if (ex_serial_commit) begin
            r_state       <= S_W_CACHE;
            r_flush_front <= 1'b0;
          end
        end
        S_W_CACHE: begin
          if (cache_idle) begin
            r_state          <= S_IDLE;
            r_redirect_valid <= 1'b0;
          end
        end
        S_W_CSR: begin
          if (ex_serial_commit) begin
            r_state       <= S_W_CSR_OK;
            r_flush_front <= 1'b0;
          end
        end
        S_W_CSR_OK: begin
          if (csr_done) begin
            r_state          <= S_IDLE;
            r_redirect_valid <= 1'b0;
          end
        end
        S_W_TLB: begin
          if (ex_serial_commit) begin
            r_state       <= S_W_TLB_OK;
            r_flush_front <= 1'b0;
          end
        end
        S_W_TLB_OK: begin
          if (tlb_done) begin
            r_state          <= S_IDLE;
            r_redirect_valid <= 1'b0;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_redirect_valid <= 1'b0;
          r_flush_front    <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush_front    = r_flush_front;

`ifdef IF1_SKID_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_serial_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_perf_stall_cnt  <= 32'd0;
      r_perf_serial_cnt <= 32'd0;
    end else begin
      if (in_valid && !in_ready && (r_perf_stall_cnt != 32'hffffffff))
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_push && w_trim && !flush && (r_perf_serial_cnt != 32'hffffffff))
        r_perf_serial_cnt <= r_perf_serial_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt  = r_perf_stall_cnt;
  assign perf_serial_cnt = r_perf_serial_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if1_fetch_skid.sv
`default_nettype none
// ============================================================================
// Module  : tb_if1_fetch_skid
// Purpose : directed self-checking bench for if1_fetch_skid (FETCH_W=2, SKID_DEPTH=2)
// Revision: 1.0 - initial release
// ============================================================================
module tb_if1_fetch_skid;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_pc_next, in_badv;
  logic [63:0] in_inst;
  logic [6:0]  in_excp;
  logic [1:0]  in_excp_flag, in_serial;
  logic [3:0]  in_serial_type;
  logic        ex_serial_commit, cache_idle, csr_done, tlb_done;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_pc_next, out_badv;
  logic [63:0] out_inst;
  logic [1:0]  out_mask, out_excp_flag;
  logic [6:0]  out_excp;
  logic        redirect_valid, flush_front;
  logic [31:0] redirect_pc;
`ifdef IF1_SKID_PERF_EN
  logic [31:0] perf_stall_cnt, perf_serial_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if1_fetch_skid dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_next(in_pc_next), .in_inst(in_inst),
    .in_badv(in_badv), .in_excp(in_excp), .in_excp_flag(in_excp_flag),
    .in_serial(in_serial), .in_serial_type(in_serial_type),
    .ex_serial_commit(ex_serial_commit), .cache_idle(cache_idle),
    .csr_done(csr_done), .tlb_done(tlb_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_inst(out_inst),
    .out_mask(out_mask), .out_badv(out_badv), .out_excp(out_excp),
    .out_excp_flag(out_excp_flag),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef IF1_SKID_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_serial_cnt(perf_serial_cnt),
`endif
    .flush_front(flush_front)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] pcn, input logic [63:0] inst,
                      input logic [1:0] ser, input logic [3:0] styp);
    in_valid = 1'b1; in_pc = pc; in_pc_next = pcn; in_inst = inst;
    in_serial = ser; in_serial_type = styp;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_pc_next = '0;
    in_inst = '0; in_badv = '0; in_excp = '0; in_excp_flag = '0; in_serial = '0;
    in_serial_type = '0; ex_serial_commit = 1'b0; cache_idle = 1'b0;
    csr_done = 1'b0; tlb_done = 1'b0; out_ready = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mask", out_mask, 0);
    chk("rst_out_pc", out_pc, 32'h1c000000);
    chk("rst_out_pc_next", out_pc_next, 32'h1c000004);
    chk("rst_out_inst", out_inst, 64'h03400000_03400000);
    chk("rst_out_badv", out_badv, 0);
    chk("rst_out_excp", out_excp, 0);
    chk("rst_out_excp_flag", out_excp_flag, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 32'h1c000000);
    chk("rst_flush_front", flush_front, 0);
    chk("rst_in_ready", in_ready, 1);
    rstn = 1'b1;

    // single push / pop
    push(32'h1c000000, 32'h1c000008, 64'h22222222_11111111, 2'b00, 4'b0000);
    tick(); in_valid = 1'b0;
    chk("p1_out_valid", out_valid, 1);
    chk("p1_out_pc", out_pc, 32'h1c000000);
    chk("p1_out_mask", out_mask, 2'b11);
    chk("p1_out_inst", out_inst, 64'h22222222_11111111);
    chk("p1_out_pc_next", out_pc_next, 32'h1c000008);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("p1_pop_valid", out_valid, 0);
    chk("p1_pop_pc", out_pc, 32'h1c000000);
    chk("p1_pop_pc_next", out_pc_next, 32'h1c000004);

    // fill, backpressure, ordered drain with simultaneous push/pop
    push(32'h1c000100, 32'h1c000108, 64'hAAAA0001_AAAA0000, 2'b00, 4'b0000); tick();
    push(32'h1c000200, 32'h1c000208, 64'hBBBB0001_BBBB0000, 2'b00, 4'b0000); tick();
    chk("full_in_ready", in_ready, 0);
    push(32'h1c000300, 32'h1c000308, 64'hCCCC0001_CCCC0000, 2'b00, 4'b0000); tick();
    chk("full_hold_in_ready", in_ready, 0);
    chk("full_head_pc", out_pc, 32'h1c000100);
    out_ready = 1'b1; tick();
    chk("drain_b_pc", out_pc, 32'h1c000200);
    chk("drain_b_in_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("drain_c_pc", out_pc, 32'h1c000300);
    chk("drain_c_inst", out_inst, 64'hCCCC0001_CCCC0000);
    tick(); out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);

    // CSR serial in slot 0; commit and csr_done together take one step only
    push(32'h1c000010, 32'h1c000018, 64'h33333333_44444444, 2'b01, 4'b0001);
    tick(); in_valid = 1'b0; in_serial = '0; in_serial_type = '0;
    chk("csr_mask", out_mask, 2'b01);
    chk("csr_inst_hi", out_inst[63:32], 32'h03400000);
    chk("csr_inst_lo", out_inst[31:0], 32'h44444444);
    chk("csr_pc_next", out_pc_next, 32'h1c000014);
    chk("csr_redirect_pc", redirect_pc, 32'h1c000014);
    chk("csr_redirect_valid", redirect_valid, 1);
    chk("csr_flush_front", flush_front, 1);
    chk("csr_in_ready", in_ready, 0);
    ex_serial_commit = 1'b1; csr_done = 1'b1; tick(); ex_serial_commit = 1'b0; csr_done = 1'b0;
    chk("csr_commit_flush_front", flush_front, 0);
    chk("csr_commit_redirect", redirect_valid, 1);
    csr_done = 1'b1; tick(); csr_done = 1'b0;
    chk("csr_done_redirect", redirect_valid, 0);
    chk("csr_done_in_ready", in_ready, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // ibar in slot 1: no slots dropped, wait on cache_idle
    push(32'h1c000020, 32'h1c000040, 64'h66666666_55555555, 2'b10, 4'b0000);
    tick(); in_valid = 1'b0; in_serial = '0;
    chk("ibar_mask", out_mask, 2'b11);
    chk("ibar_pc_next", out_pc_next, 32'h1c000028);
    chk("ibar_redirect_pc", redirect_pc, 32'h1c000028);
    chk("ibar_flush_front", flush_front, 1);
    ex_serial_commit = 1'b1; tick(); ex_serial_commit = 1'b0;
    chk("ibar_commit_flush_front", flush_front, 0);
    csr_done = 1'b1; tlb_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ibar_wait_cache", redirect_valid, 1);
    end
    csr_done = 1'b0; tlb_done = 1'b0;
    cache_idle = 1'b1; tick(); cache_idle = 1'b0;
    chk("ibar_done_redirect", redirect_valid, 0);
    chk("ibar_done_in_ready", in_ready, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // exception packet ignores in_serial
    push(32'h1c000030, 32'h1c000038, 64'h88888888_77777777, 2'b10, 4'b1000);
    in_excp_flag = 2'b01; in_excp = 7'h08; in_badv = 32'hdeadbeef;
    tick(); in_valid = 1'b0; in_serial = '0; in_excp_flag = '0; in_excp = '0; in_badv = '0;
    chk("excp_mask", out_mask, 2'b11);
    chk("excp_redirect", redirect_valid, 0);
    chk("excp_flag", out_excp_flag, 2'b01);
    chk("excp_code", out_excp, 7'h08);
    chk("excp_badv", out_badv, 32'hdeadbeef);
    chk("excp_pc_next", out_pc_next, 32'h1c000038);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // TLB serial, then flush with a push attempt in the same cycle
    push(32'h1c000050, 32'h1c000058, 64'h1, 2'b01, 4'b0010);
    tick(); in_serial = '0;
    chk("tlb_redirect", redirect_valid, 1);
    chk("tlb_flush_front", flush_front, 1);
    flush = 1'b1; tick(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_redirect", redirect_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_redirect_pc", redirect_pc, 32'h1c000000);
    chk("flush_flush_front", flush_front, 0);

    // TLB path to completion with 32-bit pc wrap
    push(32'hfffffffc, 32'h00000004, 64'h2, 2'b01, 4'b0010);
    tick(); in_valid = 1'b0; in_serial = '0;
    chk("wrap_pc_next", out_pc_next, 32'h00000000);
    chk("wrap_redirect_pc", redirect_pc, 32'h00000000);
    tlb_done = 1'b1; tick(); tlb_done = 1'b0;
    chk("tlb_early_done_ignored", redirect_valid, 1);
    ex_serial_commit = 1'b1; tick(); ex_serial_commit = 1'b0;
    chk("tlb_commit_flush_front", flush_front, 0);
    tlb_done = 1'b1; tick(); tlb_done = 1'b0;
    chk("tlb_done_redirect", redirect_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if1_fetch_skid.md
Name: if1_fetch_skid

Overview:
- Parametrised IF1→fetch-buffer stage for the front end, replacing the single-entry IF1 pipeline register plus one-deep overflow register.
- Accepts FETCH_W-instruction packets from the icache and queues them in a SKID_DEPTH-entry skid FIFO.
- Serialises ibar/CSR/TLB instructions per slot: trims the packet after the first serialising slot and drives a front-end redirect until the backend finishes the operation.

Parameters:
FETCH_W, 2, instructions per packet (1..4); slot i sits at pc+4*i
SKID_DEPTH, 2, skid FIFO entries (power of two, ≥2)
PC_RESET, 32'h1c000000, pc value driven when the head is empty
INST_NOP, 32'h03400000, fill value for masked or empty slots

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
flush  in  1  backend flush; empties block, FSM to IDLE
in_valid  in  1  icache packet valid (rready)
in_ready  out  1  block accepts packet this cycle
in_pc  in  32  packet pc, slot 0
in_pc_next  in  32  predicted next-packet pc
in_inst  in  32*FETCH_W  instructions, slot i at [32i+31:32i]
in_badv  in  32  fetch fault address
in_excp  in  7  exception code
in_excp_flag  in  2  nonzero = packet carries exception
in_serial  in  FETCH_W  per-slot serialising-instruction flag from predecoder
in_serial_type  in  2*FETCH_W  per-slot type: 0 ibar, 1 csr, 2 tlb
ex_serial_commit  in  1  serialising instruction reached EX
cache_idle  in  1  icache & dcache idle
csr_done  in  1  CSR write complete
tlb_done  in  1  TLB op complete
out_valid  out  1  head packet valid
out_ready  in  1  fetch buffer accepts head
out_pc  out  32  head pc
out_pc_next  out  32  head next pc
out_inst  out  32*FETCH_W  head instructions
out_mask  out  FETCH_W  valid slots of head
out_badv  out  32  head badv
out_excp  out  7  head exception code
out_excp_flag  out  2  head exception flag
redirect_valid  out  1  front end must fetch from redirect_pc
redirect_pc  out  32  resume pc after serialising instruction
flush_front  out  1  kill IF0/IF1 in-flight fetches

Behaviour:
- Reset (rstn=0 at clk edge): FIFO empty, state IDLE, redirect_pc=PC_RESET. Outputs: out_valid=0, out_mask=0, out_pc=PC_RESET, out_pc_next=PC_RESET+4, out_inst all INST_NOP, out_badv/out_excp/out_excp_flag=0, redirect_valid=0, flush_front=0.
- Same reset state on flush=1. flush has priority over push, pop and FSM moves in the same cycle.
- in_ready = (count<SKID_DEPTH) && state==IDLE. No push on a full FIFO, even with a simultaneous pop.
- Push happens on in_valid&&in_ready. Latency: the packet is visible at the head the cycle after the push.
- Pop happens on out_valid&&out_ready. Push and pop in the same cycle keep count unchanged; pointers wrap modulo SKID_DEPTH.
- Head empty: out_* take their reset values.
- Serial trim applies when in_excp_flag==0 and in_serial!=0:
  - k = lowest set slot; stored mask = bits 0..k set; slots >k stored as INST_NOP.
  - stored pc_next = in_pc+4*(k+1), 32-bit wrap.
  - redirect_pc <= in_pc+4*(k+1); the FSM moves per type[k].
- Without a serial trim: mask all ones, packet stored unchanged.
- A packet with in_excp_flag!=0 ignores in_serial; the exception wins.
- FSM:
  - IDLE → W_IBAR / W_CSR / W_TLB on a trimmed push.
  - W_*: flush_front=1; advance on ex_serial_commit.
  - W_IBAR → W_CACHE; W_CACHE → IDLE on cache_idle.
  - W_CSR → W_CSR_OK; W_CSR_OK → IDLE on csr_done.
  - W_TLB → W_TLB_OK; W_TLB_OK → IDLE on tlb_done.
  - Any other encoding → IDLE.
- redirect_valid = state!=IDLE (level). The FIFO keeps draining to the fetch buffer while not IDLE.
- ex_serial_commit and the done signal both high in the same cycle: one step only.

Optional Feature:
- Macro: IF1_SKID_PERF_EN.
- With it defined: extra outputs perf_stall_cnt[31:0] and perf_serial_cnt[31:0].
  - perf_stall_cnt: cycles with in_valid&&!in_ready.
  - perf_serial_cnt: count of trimmed pushes.
  - Both clear on rstn=0 only (not on flush) and saturate at 32'hffffffff.
- Without it: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then push pc=1c000000 → next cycle out_valid=1, out_pc=1c000000, out_mask=2'b11; pop → out_valid=0, out_pc=PC_RESET.
- out_ready=0, push 3 packets (SKID_DEPTH=2) → in_ready=0 after 2; third packet held by source, not lost; out_ready=1 → FIFO order preserved.
- Push pc=1c000010, in_serial=2'b01, type0=csr → out_mask=01, out_inst[63:32]=03400000, out_pc_next=1c000014, redirect_pc=1c000014, flush_front=1; ex_serial_commit → flush_front=0; csr_done → redirect_valid=0, in_ready=1.
- Serial ibar: after ex_serial_commit, hold cache_idle=0 five cycles → state stays W_CACHE; cache_idle=1 → IDLE next cycle.
- Push with in_excp_flag=2'b01 and in_serial=2'b10 → no trim, out_mask=11, no redirect.
- flush in the same cycle as push, with state W_TLB → next cycle out_valid=0, redirect_valid=0, in_ready=1.
